seg7_priority_decoder: RTL and testbench

Inverse of the priority-encoder/7-segment display path: samples a 7-segment pattern (gfedcba) plus the `none` decimal-point line and recovers the bit index as a 3-bit code and a one-hot 8-bit word. A pattern is reported only after it has been stable for a programmable number of cycles, and each distinct pattern is reported once. Results leave through a valid/ready handshake. The block sits on the input side of the tile, reading segment lines driven by an external encoder or loopback.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_classify.sv | 27 ++
 rtl/seg7_priority_decoder.sv | 169 ++++++++++++++++
 tb/tb_seg7_priority_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment priority decoder.
// Glyphs are stored gfedcba; index k holds the glyph for digit k.
package seg7_pkg;

  localparam logic [7:0][6:0] GLYPH = {
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // {none, segments} for a blank display: decimal point high, no segments lit
  localparam logic [7:0] BLANK = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PRESENT
  } state_t;

  typedef enum logic [1:0] {
    KIND_DIGIT,
    KIND_BLANK,
    KIND_ILLEGAL
  } kind_t;

endpackage

// File: rtl/seg7_classify.sv
// Combinational classifier: maps a registered {none, segments} sample to
// digit / blank / illegal, plus the digit index when it is a digit.
module seg7_classify
  import seg7_pkg::*;
(
  input  logic [7:0] pattern,
  output kind_t      kind,
  output logic [2:0] code
);

  // Match the sample against the blank pattern and the eight digit glyphs
  always_comb begin
    kind = KIND_ILLEGAL;
    code = 3'd0;
    if (pattern == BLANK) begin
      kind = KIND_BLANK;
    end else if (!pattern[7]) begin
      for (int i = 0; i < 8; i++) begin
        if (pattern[6:0] == GLYPH[i]) begin
          kind = KIND_DIGIT;
          code = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seg7_priority_decoder.sv
// Recovers the bit index from a 7-segment pattern plus decimal point.
// A pattern is reported once it has been stable for STABLE_CYCLES samples,
// and each distinct pattern is reported only once, over a valid/ready port.
// Optional feature: define SEG7_ERR_CNT_EN to add the saturating err_count
// output counting accepted illegal reports.
module seg7_priority_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments,
  input  logic       none,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic [7:0] out_onehot,
  output logic       out_none,
  output logic       out_err
`ifdef SEG7_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [7:0]    sample_q, sample_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d;
  logic [7:0]    last_q, last_d;
  logic          last_vld_q, last_vld_d;
  logic [7:0]    rep_q, rep_d;
  state_t        state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [2:0]    out_code_q, out_code_d;
  logic [7:0]    out_onehot_q, out_onehot_d;
  logic          out_none_q, out_none_d;
  logic          out_err_q, out_err_d;
`ifdef SEG7_ERR_CNT_EN
  logic [7:0]    err_count_q, err_count_d;
`endif

  kind_t      kind;
  logic [2:0] code;
  logic       is_new;

  seg7_classify u_classify (
    .pattern (sample_q),
    .kind    (kind),
    .code    (code)
  );

  // primed_q keeps the post-reset zero sample from looking stable when
  // STABLE_CYCLES is 1 and the counter is already at its limit.
  // Next-state logic for the sampler, stability counter, FSM and outputs
  always_comb begin
    sample_d     = {none, segments};
    primed_d     = 1'b1;
    last_d       = last_q;
    last_vld_d   = last_vld_q;
    rep_d        = rep_q;
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_code_d   = out_code_q;
    out_onehot_d = out_onehot_q;
    out_none_d   = out_none_q;
    out_err_d    = out_err_q;
`ifdef SEG7_ERR_CNT_EN
    err_count_d  = err_count_q;
`endif

    is_new = !last_vld_q || (sample_q != last_q);

    if (sample_d != sample_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (is_new) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (is_new && primed_q && (cnt_q == CNT_MAX)) begin
          state_d      = PRESENT;
          rep_d        = sample_q;
          out_valid_d  = 1'b1;
          out_code_d   = (kind == KIND_DIGIT) ? code : 3'd0;
          out_onehot_d = (kind == KIND_DIGIT) ? (8'd1 << code) : 8'd0;
          out_none_d   = (kind == KIND_BLANK);
          out_err_d    = (kind == KIND_ILLEGAL);
        end else if (!is_new) begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d     = SETTLE;
          out_valid_d = 1'b0;
          last_d      = rep_q;
          last_vld_d  = 1'b1;
`ifdef SEG7_ERR_CNT_EN
          if (out_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
          end
`endif
        end
      end
      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q     <= 8'd0;
      cnt_q        <= '0;
      primed_q     <= 1'b0;
      last_q       <= 8'd0;
      last_vld_q   <= 1'b0;
      rep_q        <= 8'd0;
      state_q      <= SETTLE;
      out_valid_q  <= 1'b0;
      out_code_q   <= 3'd0;
      out_onehot_q <= 8'd0;
      out_none_q   <= 1'b0;
      out_err_q    <= 1'b0;
`ifdef SEG7_ERR_CNT_EN
      err_count_q  <= 8'd0;
`endif
    end else begin
      sample_q     <= sample_d;
      cnt_q        <= cnt_d;
      primed_q     <= primed_d;
      last_q       <= last_d;
      last_vld_q   <= last_vld_d;
      rep_q        <= rep_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_code_q   <= out_code_d;
      out_onehot_q <= out_onehot_d;
      out_none_q   <= out_none_d;
      out_err_q    <= out_err_d;
`ifdef SEG7_ERR_CNT_EN
      err_count_q  <= err_count_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_code   = out_code_q;
  assign out_onehot = out_onehot_q;
  assign out_none   = out_none_q;
  assign out_err    = out_err_q;
`ifdef SEG7_ERR_CNT_EN
  assign err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_seg7_priority_decoder.sv
// Scoreboard bench for seg7_priority_decoder (default STABLE_CYCLES = 4).
// Stimulus pushes expected reports into a queue; a monitor pops one on every
// accepted handshake. With SEG7_ERR_CNT_EN defined err_count is also checked.
module tb_seg7_priority_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] segments = 7'd0;
  logic       none = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_code;
  logic [7:0] out_onehot;
  logic       out_none;
  logic       out_err;
`ifdef SEG7_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int total = 0;
  int bad = 0;
  logic [12:0] exp_q[$];

  seg7_priority_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .segments   (segments),
    .none       (none),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_onehot (out_onehot),
    .out_none   (out_none),
    .out_err    (out_err)
`ifdef SEG7_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] seg, input logic nn);
    segments = seg;
    none = nn;
  endtask

  task automatic expectReport(input logic [2:0] code, input logic [7:0] onehot,
                              input logic nn, input logic err);
    exp_q.push_back({code, onehot, nn, err});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitValid(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!out_valid && edges < 40);
  endtask

  // Monitor: every accepted handshake must match the oldest expected report
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_report", 1, 0);
      end else begin
        checkOutput("report", int'({out_code, out_onehot, out_none, out_err}),
                    int'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog so the bench can never hang
  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    int lat;
    int n;

    tick(3);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_code", out_code, 0);
    checkOutput("reset_onehot", out_onehot, 0);
    checkOutput("reset_none", out_none, 0);
    checkOutput("reset_err", out_err, 0);
`ifdef SEG7_ERR_CNT_EN
    checkOutput("reset_err_count", err_count, 0);
`endif

    out_ready = 1'b1;
    expectReport(3'd4, 8'h10, 1'b0, 1'b0);
    applyStimulus(7'h66, 1'b0);
    rst = 1'b0;
    waitValid(lat);
    checkOutput("latency_66", lat, 5);
    checkOutput("code_66", out_code, 4);
    checkOutput("onehot_66", out_onehot, 8'h10);
    n = 0;
    repeat (20) begin
      tick(1);
      if (out_valid) n++;
    end
    checkOutput("no_repeat_66", n, 0);

    applyStimulus(7'h07, 1'b0);
    tick(3);
    applyStimulus(7'h66, 1'b0);
    n = 0;
    repeat (10) begin
      tick(1);
      if (out_valid) n++;
    end
    checkOutput("glitch_suppressed", n, 0);

    expectReport(3'd7, 8'h80, 1'b0, 1'b0);
    applyStimulus(7'h07, 1'b0);
    waitValid(lat);
    checkOutput("latency_07", lat, 5);
    checkOutput("code_07", out_code, 7);
    checkOutput("onehot_07", out_onehot, 8'h80);
    tick(1);

    expectReport(3'd0, 8'h00, 1'b1, 1'b0);
    applyStimulus(7'h00, 1'b1);
    waitValid(lat);
    checkOutput("blank_none", out_none, 1);
    checkOutput("blank_onehot", out_onehot, 0);
    tick(1);

    expectReport(3'd0, 8'h00, 1'b0, 1'b1);
    applyStimulus(7'h06, 1'b1);
    waitValid(lat);
    checkOutput("illegal_err", out_err, 1);
    checkOutput("illegal_onehot", out_onehot, 0);
    tick(1);
`ifdef SEG7_ERR_CNT_EN
    checkOutput("err_count_one", err_count, 1);
`endif

    out_ready = 1'b0;
    expectReport(3'd2, 8'h04, 1'b0, 1'b0);
    applyStimulus(7'h5B, 1'b0);
    waitValid(lat);
    checkOutput("latency_5b", lat, 5);
    applyStimulus(7'h4F, 1'b0);
    expectReport(3'd3, 8'h08, 1'b0, 1'b0);
    n = 0;
    repeat (8) begin
      tick(1);
      if (out_valid && out_code == 3'd2 && out_onehot == 8'h04) n++;
    end
    checkOutput("hold_while_stalled", n, 8);
    out_ready = 1'b1;
    tick(1);
    checkOutput("valid_gap_after_accept", out_valid, 0);
    tick(1);
    checkOutput("rereport_valid", out_valid, 1);
    checkOutput("rereport_code", out_code, 3);
    tick(1);

    out_ready = 1'b0;
    expectReport(3'd6, 8'h40, 1'b0, 1'b0);
    applyStimulus(7'h7D, 1'b0);
    waitValid(lat);
    checkOutput("latency_7d", lat, 5);
    rst = 1'b1;
    tick(1);
    checkOutput("midreset_valid", out_valid, 0);
    checkOutput("midreset_code", out_code, 0);
    checkOutput("midreset_onehot", out_onehot, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    waitValid(lat);
    checkOutput("latency_after_reset", lat, 5);
    checkOutput("code_after_reset", out_code, 6);
    tick(1);

    for (int i = 0; i < 300; i++) begin
      expectReport(3'd0, 8'h00, 1'b0, 1'b1);
      applyStimulus(7'((i % 127) + 1), 1'b1);
      waitValid(lat);
      checkOutput("illegal_latency", lat, 5);
      tick(1);
    end
`ifdef SEG7_ERR_CNT_EN
    checkOutput("err_count_saturated", err_count, 255);
`endif

    tick(3);
    checkOutput("pending_reports", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
